// File: rtl/alarm_pkg.sv
// alarm_pkg: values shared by the keypad time-entry loader, the time counter
// and the alarm register.
//   - key codes for the '*' (start/commit) and '#' (cancel) keys
//   - entry FSM state encoding
//   - per-digit limits of a valid 24-hour HH:MM time
package alarm_pkg;

  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_HASH  = 4'd11;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

  localparam logic [3:0] MAX_MS_HR      = 4'd2;
  localparam logic [3:0] MAX_LS_HR_AT_2 = 4'd3;
  localparam logic [3:0] MAX_MS_MIN     = 4'd5;
  localparam logic [3:0] MAX_LS_MIN     = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2
  } entry_state_e;

endpackage

// File: rtl/time_entry_loader_if.sv
// time_entry_loader_if: load bus from the entry loader to the time counter.
//   new_current_time_{ms,ls}_{hr,min} : BCD digits of the time to load
//   load_new_c                        : one-cycle load strobe
//   master = loader (drives), slave = time counter (receives)
interface time_entry_loader_if;
  logic [3:0] new_current_time_ms_hr;
  logic [3:0] new_current_time_ls_hr;
  logic [3:0] new_current_time_ms_min;
  logic [3:0] new_current_time_ls_min;
  logic       load_new_c;

  modport master (
    output new_current_time_ms_hr, new_current_time_ls_hr,
           new_current_time_ms_min, new_current_time_ls_min, load_new_c
  );

  modport slave (
    input  new_current_time_ms_hr, new_current_time_ls_hr,
           new_current_time_ms_min, new_current_time_ls_min, load_new_c
  );
endinterface

// File: rtl/time_validator.sv
// time_validator: combinational check that four BCD digits form a legal
// 24-hour time HH:MM (00:00 .. 23:59).
//   ms_hr, ls_hr, ms_min, ls_min : input digits
//   valid                        : high when the digits are a legal time
module time_validator
  import alarm_pkg::*;
(
  input  logic [3:0] ms_hr,
  input  logic [3:0] ls_hr,
  input  logic [3:0] ms_min,
  input  logic [3:0] ls_min,
  output logic       valid
);

  always_comb begin
    valid = (ms_hr <= MAX_MS_HR)
         && ((ms_hr != MAX_MS_HR) || (ls_hr <= MAX_LS_HR_AT_2))
         && (ls_hr <= KEY_DIGIT_MAX)
         && (ms_min <= MAX_MS_MIN)
         && (ls_min <= MAX_LS_MIN);
  end

endmodule

// File: rtl/time_entry_loader.sv
// time_entry_loader: collects keypad digits into a 4-digit HH:MM entry
// buffer, validates it on '*' commit and strobes it into the time counter.
//   clk, reset   : clock, synchronous active-high reset
//   key_valid    : one-cycle key strobe; key = 0-9 digit, 10 '*', 11 '#'
//   one_second   : one-cycle tick per second (inactivity timeout)
//   load_bus     : entry buffer digits + one-cycle load_new_c strobe
//   entry_active : high while an entry is in progress
//   digit_count  : digits captured so far (0..4)
//   entry_error  : one-cycle pulse on invalid/premature commit or timeout
module time_entry_loader
  import alarm_pkg::*;
#(
  parameter int unsigned TIMEOUT_SECS = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_valid,
  input  logic [3:0]                 key,
  input  logic                       one_second,
  time_entry_loader_if.master        load_bus,
  output logic                       entry_active,
  output logic [2:0]                 digit_count,
  output logic                       entry_error
);

  localparam logic [3:0] TIMEOUT_L = 4'(TIMEOUT_SECS);

  entry_state_e state_q, state_d;
  logic [3:0] ms_hr_q, ms_hr_d, ls_hr_q, ls_hr_d;
  logic [3:0] ms_min_q, ms_min_d, ls_min_q, ls_min_d;
  logic [3:0] timer_q, timer_d;
  logic [2:0] cnt_q, cnt_d;
  logic       load_q, load_d;
  logic       err_q, err_d;
  logic       active_q, active_d;
  logic       time_ok;

  time_validator u_validator (
    .ms_hr  (ms_hr_q),
    .ls_hr  (ls_hr_q),
    .ms_min (ms_min_q),
    .ls_min (ls_min_q),
    .valid  (time_ok)
  );

  always_comb begin
    state_d  = state_q;
    ms_hr_d  = ms_hr_q;
    ls_hr_d  = ls_hr_q;
    ms_min_d = ms_min_q;
    ls_min_d = ls_min_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    load_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (key_valid && (key == KEY_STAR)) begin
          state_d  = ST_ENTRY;
          ms_hr_d  = '0;
          ls_hr_d  = '0;
          ms_min_d = '0;
          ls_min_d = '0;
          cnt_d    = '0;
          timer_d  = '0;
        end
      end
      ST_ENTRY: begin
        // Any key press, even an ignored one, counts as activity.
        if (key_valid) begin
          timer_d = '0;
          if (key <= KEY_DIGIT_MAX) begin
            if (cnt_q < 3'd4) begin
              ms_hr_d  = ls_hr_q;
              ls_hr_d  = ms_min_q;
              ms_min_d = ls_min_q;
              ls_min_d = key;
              cnt_d    = cnt_q + 3'd1;
            end
          end else if (key == KEY_HASH) begin
            state_d = ST_IDLE;
          end else if (key == KEY_STAR) begin
            if ((cnt_q == 3'd4) && time_ok) begin
              state_d = ST_LOAD;
              load_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end
          end
        end else if (one_second) begin
          timer_d = timer_q + 4'd1;
          if (timer_d == TIMEOUT_L) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    active_d = (state_d == ST_ENTRY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ms_hr_q  <= '0;
      ls_hr_q  <= '0;
      ms_min_q <= '0;
      ls_min_q <= '0;
      timer_q  <= '0;
      cnt_q    <= '0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ms_hr_q  <= ms_hr_d;
      ls_hr_q  <= ls_hr_d;
      ms_min_q <= ms_min_d;
      ls_min_q <= ls_min_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  assign load_bus.new_current_time_ms_hr  = ms_hr_q;
  assign load_bus.new_current_time_ls_hr  = ls_hr_q;
  assign load_bus.new_current_time_ms_min = ms_min_q;
  assign load_bus.new_current_time_ls_min = ls_min_q;
  assign load_bus.load_new_c              = load_q;
  assign entry_active                     = active_q;
  assign digit_count                      = cnt_q;
  assign entry_error                      = err_q;

endmodule

// File: tb/tb_time_entry_loader.sv
module tb_time_entry_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key;
  logic       one_second;
  logic       entry_active;
  logic [2:0] digit_count;
  logic       entry_error;

  time_entry_loader_if bus ();

  time_entry_loader #(.TIMEOUT_SECS(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key          (key),
    .one_second   (one_second),
    .load_bus     (bus),
    .entry_active (entry_active),
    .digit_count  (digit_count),
    .entry_error  (entry_error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_load;
    logic [15:0] digits;
    int unsigned cyc;
  } exp_t;

  exp_t sbq[$];
  int   passed = 0;
  int   total  = 0;

  localparam logic [3:0] STAR = 4'd10;
  localparam logic [3:0] HASH = 4'd11;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] digits();
    return {bus.new_current_time_ms_hr, bus.new_current_time_ls_hr,
            bus.new_current_time_ms_min, bus.new_current_time_ls_min};
  endfunction

  // One stimulus cycle, then one idle cycle. When ev is set, the DUT must
  // answer in the cycle right after the sampling edge.
  task automatic drive(input bit kv, input logic [3:0] k, input bit tick,
                       input bit ev, input bit is_load, input logic [15:0] d);
    exp_t e;
    @(negedge clk);
    key_valid  = kv;
    key        = k;
    one_second = tick;
    if (ev) begin
      e.is_load = is_load;
      e.digits  = d;
      e.cyc     = cyc + 1;
      sbq.push_back(e);
    end
    @(negedge clk);
    key_valid  = 1'b0;
    one_second = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    drive(1'b1, k, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic press_load(input logic [15:0] d);
    drive(1'b1, STAR, 1'b0, 1'b1, 1'b1, d);
  endtask

  task automatic press_err(input logic [15:0] d);
    drive(1'b1, STAR, 1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  // Monitor: every load/error strobe must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.load_new_c || entry_error) begin
        if (sbq.size() == 0) begin
          check("unexpected_strobe", {30'd0, bus.load_new_c, entry_error}, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("strobe_load",   {31'd0, bus.load_new_c}, {31'd0, e.is_load});
          check("strobe_error",  {31'd0, entry_error},    {31'd0, !e.is_load});
          check("strobe_cycle",  cyc,                     e.cyc);
          check("strobe_digits", {16'd0, digits()},       {16'd0, e.digits});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; key_valid = 1'b0; key = 4'd0; one_second = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_digits", {16'd0, digits()}, 32'h0);
    check("reset_load",   {31'd0, bus.load_new_c}, 32'd0);
    check("reset_error",  {31'd0, entry_error}, 32'd0);
    check("reset_active", {31'd0, entry_active}, 32'd0);
    check("reset_count",  {29'd0, digit_count}, 32'd0);
    reset = 1'b0;

    // Valid entry 12:34
    press(STAR);
    check("active_after_star", {31'd0, entry_active}, 32'd1);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check("count_four", {29'd0, digit_count}, 32'd4);
    press_load(16'h1234);
    check("digits_held_1234", {16'd0, digits()}, 32'h1234);

    // Invalid 24:00, then valid 23:59
    press(STAR); press(4'd2); press(4'd4); press(4'd0); press(4'd0);
    press_err(16'h2400);
    check("idle_after_invalid", {31'd0, entry_active}, 32'd0);
    press(STAR); press(4'd2); press(4'd3); press(4'd5); press(4'd9);
    press_load(16'h2359);

    // Invalid minutes 19:60
    press(STAR); press(4'd1); press(4'd9); press(4'd6); press(4'd0);
    press_err(16'h1960);

    // Premature commit, then fifth digit ignored
    press(STAR); press(4'd1); press(4'd2);
    press_err(16'h0012);
    press(STAR); press(4'd0); press(4'd9); press(4'd3); press(4'd0); press(4'd5);
    check("fifth_digit_ignored", {16'd0, digits()}, 32'h0930);
    check("count_saturates", {29'd0, digit_count}, 32'd4);
    press(4'd13);
    press_load(16'h0930);

    // Keys ignored in IDLE, including a digit and '#'
    press(4'd7); press(HASH);
    check("idle_keys_ignored", {16'd0, digits()}, 32'h0930);

    // Timeout: error on the tick that brings the timer to 10
    press(STAR); press(4'd1);
    ticks(9);
    check("active_before_timeout", {31'd0, entry_active}, 32'd1);
    drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0001);
    check("active_after_timeout", {31'd0, entry_active}, 32'd0);

    // Key coinciding with a tick restarts the count
    press(STAR); press(4'd1);
    ticks(5);
    drive(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 16'h0);
    ticks(9);
    check("no_timeout_after_restart", {31'd0, entry_active}, 32'd1);
    check("coincident_digit_taken", {16'd0, digits()}, 32'h0012);
    press(HASH);

    // Cancel keeps buffer, no strobe
    press(STAR); press(4'd1); press(4'd2); press(HASH);
    check("cancel_idle", {31'd0, entry_active}, 32'd0);
    check("cancel_keeps_buffer", {16'd0, digits()}, 32'h0012);

    // Reset mid-entry
    press(STAR); press(4'd5);
    check("partial_digit", {16'd0, digits()}, 32'h0005);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midreset_digits", {16'd0, digits()}, 32'h0);
    check("midreset_active", {31'd0, entry_active}, 32'd0);
    check("midreset_count",  {29'd0, digit_count}, 32'd0);
    press(4'd3);
    check("idle_after_midreset", {16'd0, digits()}, 32'h0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/time_entry_loader.md
Name: time_entry_loader

Overview:
- Producer side of the clock counter's load interface.
- Collects keypad digits into a 4-digit BCD entry buffer (HH:MM) and validates it as a 24-hour time.
- On a valid commit, presents the digits on new_current_time_* and pulses load_new_c for one cycle.
- Sits between the keypad decoder and the time counter; aborts the entry on cancel or inactivity timeout.

Parameters:
- TIMEOUT_SECS, 10, number of one_second ticks without a key press after which an entry in progress is abandoned (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- key_valid  input  1  one-cycle strobe; key is valid when high
- key  input  4  key code: 0-9 digit, 10 = '*' (start/commit), 11 = '#' (cancel), 12-15 ignored
- one_second  input  1  one-cycle tick, once per second
- new_current_time_ms_hr  output  4  entry buffer, tens of hours
- new_current_time_ls_hr  output  4  entry buffer, units of hours
- new_current_time_ms_min  output  4  entry buffer, tens of minutes
- new_current_time_ls_min  output  4  entry buffer, units of minutes
- load_new_c  output  1  one-cycle load strobe to the time counter
- entry_active  output  1  high while in ENTRY state
- digit_count  output  3  digits captured so far (0..4)
- entry_error  output  1  one-cycle pulse: invalid time, premature commit, or timeout

Behaviour:
Reset (synchronous):
- All four buffer outputs = 0, load_new_c = 0, entry_error = 0, digit_count = 0.
- entry_active = 0, timeout counter = 0, state = IDLE.
- Reset asserted mid-entry discards the partial entry.

States: IDLE, ENTRY, LOAD. All outputs are registered.

IDLE:
- key_valid with key 10 -> ENTRY. Buffer cleared to 0000, digit_count = 0, timer = 0.
- All other keys are ignored.

ENTRY:
- Digit key (0-9) with digit_count < 4: shift left one digit, i.e. ms_hr <= ls_hr, ls_hr <= ms_min, ms_min <= ls_min, ls_min <= key. digit_count += 1, timer cleared.
- Digit key with digit_count == 4: ignored, buffer unchanged, but timer is still cleared.
- Key 11: -> IDLE. Buffer retains its contents; no error, no load.
- Key 10 with digit_count < 4: entry_error pulse, -> IDLE.
- Key 10 with digit_count == 4: run validation.
  - Valid -> LOAD.
  - Invalid -> entry_error pulse, -> IDLE, no load.
- Keys 12-15: ignored, but timer is still cleared.
- one_second with no key_valid in the same cycle: timer += 1. When timer reaches TIMEOUT_SECS: entry_error pulse, -> IDLE.
- key_valid and one_second in the same cycle: the key wins and the timer clears.

Validation (combinational on the buffer):
- ms_hr <= 2; if ms_hr == 2 then ls_hr <= 3; ms_min <= 5; ls_min <= 9.
- 23:59 is valid; 24:00, 19:60 and 2x:xx with ls_hr > 3 are invalid.

LOAD:
- load_new_c = 1 for exactly this one cycle, then -> IDLE unconditionally.
- key_valid during LOAD is ignored.

Timing and output stability:
- Latency: commit key sampled in cycle N -> load_new_c high in cycle N+1, low in N+2.
- Buffer outputs are stable from the commit through the load cycle and are held afterwards until the next '*'.
- entry_error is high for exactly one cycle per event.

Decomposition:
- Shared package alarm_pkg:
  - key code constants KEY_STAR = 4'd10, KEY_HASH = 4'd11
  - state encoding for IDLE/ENTRY/LOAD
  - limit constants MAX_MS_HR = 2, MAX_LS_HR_AT_2 = 3, MAX_MS_MIN = 5, MAX_LS_MIN = 9, reused by the time counter and alarm register.
- One sub-module is natural: time_validator, purely combinational. It takes the four digits and returns valid, and can be reused when alarm times are entered.

Test Plan:
- '*', 1, 2, 3, 4, '*' -> buffer 12:34, load_new_c high exactly in the cycle after the second '*', entry_error stays 0.
- '*', 2, 4, 0, 0, '*' -> entry_error one-cycle pulse, load_new_c never asserted, state IDLE; repeat with 2, 3, 5, 9 -> load of 23:59.
- '*', 1, 2, '*' -> entry_error pulse, no load; then '*', 0, 9, 3, 0, 5, '*' -> fifth digit ignored, load of 09:30.
- '*', 1, then TIMEOUT_SECS one_second ticks with no key -> entry_error on the tick that reaches 10, entry_active drops; a key coinciding with a tick restarts the count (no error at 10).
- '*', 1, 2, '#' -> IDLE, no load, no error, buffer still 00:12; reset asserted mid-entry after '*', 5 -> all outputs 0 the next cycle.
